// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields and pipeline controls in, registered EX fields and status out.
// Latency: wires only; the registered behaviour lives in id_ex_stage.
// Backpressure: hold freezes the stage; stall_if_id asks IF/ID to freeze on a load-use hazard.
// Ports: master = ID/control side (drives id_*, flush, hold); slave = the stage (drives ex_*, stall, counters).
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch;
  logic [3:0]      id_alu_op;
  logic            flush, hold;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
  logic [3:0]      ex_alu_op;
  logic            stall_if_id;
  logic [CNT_W-1:0] bubble_count, flush_count;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch,
           id_alu_op, flush, hold,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch,
           ex_alu_op, stall_if_id, bubble_count, flush_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch,
           id_alu_op, flush, hold,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch,
           ex_alu_op, stall_if_id, bubble_count, flush_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble/flush insertion and event counters.
// Latency: one cycle ID->EX; stall_if_id is combinational from EX state and ID inputs.
// Backpressure: hold freezes every register; a load-use hazard inserts one bubble and stalls IF/ID.
// Ports: clk, reset (async, active-high), bus (id_ex_stage_if.slave).
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            branch;
    logic [3:0]      alu_op;
  } stage_t;

  stage_t           ex_q;
  stage_t           id_d;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             load_use;

  always_comb begin
    id_d            = '0;
    id_d.valid      = 1'b1;
    id_d.pc         = bus.id_pc;
    id_d.rs1_data   = bus.id_rs1_data;
    id_d.rs2_data   = bus.id_rs2_data;
    id_d.imm        = bus.id_imm;
    id_d.rs1        = bus.id_rs1;
    id_d.rs2        = bus.id_rs2;
    id_d.rd         = bus.id_rd;
    id_d.reg_write  = bus.id_reg_write;
    id_d.mem_read   = bus.id_mem_read;
    id_d.mem_write  = bus.id_mem_write;
    id_d.mem_to_reg = bus.id_mem_to_reg;
    id_d.alu_src    = bus.id_alu_src;
    id_d.branch     = bus.id_branch;
    id_d.alu_op     = bus.id_alu_op;
  end

  // A load in EX whose destination feeds the ID instruction; x0 is never a real dependency.
  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & bus.id_valid &
                    ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));

  // A flush discards the ID instruction anyway, and a hold freezes everything, so neither stalls.
  assign bus.stall_if_id = load_use & ~bus.flush & ~bus.hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q       <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (bus.hold) begin
      // Everything frozen; a branch sitting in EX re-raises flush once hold drops.
      ex_q <= ex_q;
    end else if (bus.flush) begin
      ex_q <= '0;
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end else if (load_use) begin
      ex_q <= '0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else if (!bus.id_valid) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rs1_data   = ex_q.rs1_data;
  assign bus.ex_rs2_data   = ex_q.rs2_data;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.bubble_count  = bubble_cnt;
  assign bus.flush_count   = flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expected EX state, a monitor compares.
// Latency: expectations apply after the edge following each vector; stall is checked before it.
// Backpressure: exercises hold, flush, load-use bubbles, async reset and counter saturation.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int M_LOAD = 0;
  localparam int M_BUB  = 1;
  localparam int M_KEEP = 2;

  // ctl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[3:0]}
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  ctl;
  } instr_t;

  typedef struct packed {
    logic   is_async;
    logic   stall;
    instr_t ex;
    logic [CNT_W-1:0] bc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t   q[$];
  instr_t last_ex = '0;
  int     n_vec = 0;
  int     n_err = 0;

  function automatic instr_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic [9:0] ctl,
                                input logic [31:0] imm);
    instr_t i;
    i.valid = v; i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.ctl = ctl; i.imm = imm;
    i.d1 = 32'hA000_0000 | pc; i.d2 = 32'hB000_0000 | pc;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    bus.id_valid = i.valid; bus.id_pc = i.pc; bus.id_rs1_data = i.d1; bus.id_rs2_data = i.d2;
    bus.id_imm = i.imm; bus.id_rs1 = i.rs1; bus.id_rs2 = i.rs2; bus.id_rd = i.rd;
    {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg,
     bus.id_alu_src, bus.id_branch, bus.id_alu_op} = i.ctl;
  endtask

  task automatic step(input instr_t i, input logic fl, input logic hd, input int mode,
                      input logic stall, input int bc, input int fc);
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    drive(i);
    bus.flush = fl;
    bus.hold  = hd;
    e.is_async = 1'b0;
    e.stall = stall;
    e.bc = CNT_W'(bc);
    e.fc = CNT_W'(fc);
    case (mode)
      M_LOAD:  e.ex = i;
      M_BUB:   e.ex = '0;
      default: e.ex = last_ex;
    endcase
    last_ex = e.ex;
    q.push_back(e);
  endtask

  // Reset asserted mid-cycle: outputs must clear before the next rising edge.
  task automatic async_reset();
    exp_t e;
    @(negedge clk);
    drive('0);
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    reset = 1'b1;
    e = '0;
    e.is_async = 1'b1;
    last_ex = '0;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, n_vec, act, expv);
    end
  endtask

  task automatic chk_outputs(input exp_t e);
    chk("ex_valid", 32'(bus.ex_valid), 32'(e.ex.valid));
    chk("ex_pc", bus.ex_pc, e.ex.pc);
    chk("ex_rs1_data", bus.ex_rs1_data, e.ex.d1);
    chk("ex_rs2_data", bus.ex_rs2_data, e.ex.d2);
    chk("ex_imm", bus.ex_imm, e.ex.imm);
    chk("ex_rs1", 32'(bus.ex_rs1), 32'(e.ex.rs1));
    chk("ex_rs2", 32'(bus.ex_rs2), 32'(e.ex.rs2));
    chk("ex_rd", 32'(bus.ex_rd), 32'(e.ex.rd));
    chk("ex_ctl", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg,
                       bus.ex_alu_src, bus.ex_branch, bus.ex_alu_op}), 32'(e.ex.ctl));
    chk("bubble_count", 32'(bus.bubble_count), 32'(e.bc));
    chk("flush_count", 32'(bus.flush_count), 32'(e.fc));
  endtask

  // Monitor: stall is checked while the vector is applied, EX state just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_vec++;
        if (e.is_async) begin
          chk_outputs(e);
        end else begin
          chk("stall_if_id", 32'(bus.stall_if_id), 32'(e.stall));
          @(posedge clk);
          #1;
          chk_outputs(e);
        end
      end
    end
  end

  initial begin
    instr_t a, ld, dep, ld0, z, ld4, f, inv, dd;
    a   = mk(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 10'b1_0000_0_0010, 32'h0);
    ld  = mk(1'b1, 32'h104, 5'd5, 5'd0, 5'd3, 10'b1_1010_0_0000, 32'h8);
    dep = mk(1'b1, 32'h108, 5'd6, 5'd3, 5'd7, 10'b1_0000_0_0011, 32'h0);
    ld0 = mk(1'b1, 32'h10C, 5'd0, 5'd0, 5'd0, 10'b1_1010_0_0000, 32'h4);
    z   = mk(1'b1, 32'h110, 5'd0, 5'd0, 5'd9, 10'b1_0000_0_0001, 32'h0);
    ld4 = mk(1'b1, 32'h114, 5'd1, 5'd0, 5'd4, 10'b1_1010_0_0000, 32'hC);
    f   = mk(1'b1, 32'h118, 5'd4, 5'd8, 5'd10, 10'b0_0000_1_0101, 32'h20);
    inv = mk(1'b0, 32'h11C, 5'd4, 5'd4, 5'd11, 10'b1_0000_0_0110, 32'h30);
    dd  = mk(1'b1, 32'h120, 5'd3, 5'd3, 5'd12, 10'b1_0000_0_0111, 32'h0);
    drive('0);
    bus.flush = 1'b0;
    bus.hold  = 1'b0;

    // Power-on reset state.
    @(negedge clk);
    begin
      exp_t e;
      e = '0;
      e.is_async = 1'b1;
      q.push_back(e);
    end

    step(a,   0, 0, M_LOAD, 0, 0, 0);  // pass-through
    step(ld,  0, 0, M_LOAD, 0, 0, 0);  // rs1 matches ex_rd but EX is not a load
    step(dep, 0, 0, M_BUB,  1, 1, 0);  // load-use on rs2
    step(dep, 0, 0, M_LOAD, 0, 1, 0);  // dependent instruction proceeds
    step(ld0, 0, 0, M_LOAD, 0, 1, 0);
    step(z,   0, 0, M_LOAD, 0, 1, 0);  // load to x0 never stalls
    step(ld4, 0, 0, M_LOAD, 0, 1, 0);
    step(f,   1, 0, M_BUB,  0, 1, 1);  // flush beats load-use
    step(ld4, 0, 0, M_LOAD, 0, 1, 1);
    for (int k = 0; k < 3; k++) step(f, 1, 1, M_KEEP, 0, 1, 1);  // hold freezes all
    step(f,   1, 0, M_BUB,  0, 1, 2);  // flush lands once hold drops
    step(inv, 0, 0, M_BUB,  0, 1, 2);  // empty ID slot: bubble, no count
    step(ld,  0, 0, M_LOAD, 0, 1, 2);
    step(dd,  0, 0, M_BUB,  1, 2, 2);  // rd matches both sources: one bubble
    step(dd,  0, 0, M_LOAD, 0, 2, 2);
    step(dep, 0, 0, M_LOAD, 0, 2, 2);  // ex_rd = 7 in EX
    async_reset();
    step(a,   0, 0, M_LOAD, 0, 0, 0);  // first capture after reset
    for (int k = 1; k <= 20; k++) step(a, 1, 0, M_BUB, 0, 0, (k > 15) ? 15 : k);
    step(a,   0, 0, M_LOAD, 0, 0, 15);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
